// File: rtl/motor_ramp_pwm.sv
// Purpose: H-bridge PWM driver with slew-limited speed ramp, safe reversal, active brake and status.
// Latency: PWM legs lag the counter compare by 1 clock; speed/direction are sampled at period boundaries.
// Backpressure: none, free-running; brake_in overrides everything except reset.
//
// Ports:
//   clk_in, reset_in      : clock (rising edge), synchronous active-low reset
//   speed, direction      : commanded duty (0 = stop) and direction (1 = forward on motor_plus)
//   brake_in              : level-sensitive active brake request (both legs high)
//   motor_plus/minus      : registered H-bridge leg drives
//   speed_out, dir_out    : currently applied duty and direction
//   at_speed, reversing   : status (settled in IDLE/RUN; in a reversal sequence)
module motor_ramp_pwm #(
  parameter int CLK_DIV      = 50,
  parameter int WIDTH        = 8,
  parameter int RAMP_STEP    = 1,
  parameter int DEAD_PERIODS = 2
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic [WIDTH-1:0] speed,
  input  logic             direction,
  input  logic             brake_in,
  output logic             motor_plus,
  output logic             motor_minus,
  output logic [WIDTH-1:0] speed_out,
  output logic             dir_out,
  output logic             at_speed,
  output logic             reversing
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = $clog2(DEAD_PERIODS + 1);
  localparam logic [PW-1:0]    PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [WIDTH:0]   STEP      = (WIDTH+1)'(RAMP_STEP);
  localparam logic [DW-1:0]    DEAD_LOAD = DW'(DEAD_PERIODS);

  typedef enum logic [2:0] {IDLE, RUN, DECEL, DEAD, BRAKE} state_t;

  state_t           state, state_nx;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] pwm_cnt;
  logic [DW-1:0]    dead_cnt, dead_nx;
  logic [WIDTH-1:0] speed_nx;
  logic             dir_nx;

  logic tick, pb, pwm_on;
  logic [WIDTH-1:0] ramp_down, ramp_from_zero, ramp_run;

  // Move cur toward goal by at most STEP; one extra bit keeps the
  // difference and the sum from wrapping.
  function automatic logic [WIDTH-1:0] ramp_to(input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] goal);
    logic [WIDTH:0] c;
    logic [WIDTH:0] g;
    c = {1'b0, cur};
    g = {1'b0, goal};
    if (g >= c) ramp_to = ((g - c) <= STEP) ? goal : WIDTH'(c + STEP);
    else        ramp_to = ((c - g) <= STEP) ? goal : WIDTH'(c - STEP);
  endfunction

  assign tick   = (presc == PRESC_MAX);
  assign pb     = tick && (pwm_cnt == CNT_MAX);
  assign pwm_on = (speed_out > pwm_cnt);

  assign ramp_down      = ramp_to(speed_out, '0);
  assign ramp_from_zero = ramp_to('0, speed);
  assign ramp_run       = ramp_to(speed_out, speed);

  always_comb begin
    state_nx = state;
    speed_nx = speed_out;
    dir_nx   = dir_out;
    dead_nx  = dead_cnt;
    if (brake_in) begin
      state_nx = BRAKE;
      speed_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          dir_nx   = direction;
          speed_nx = '0;
          if (pb && speed != '0) begin
            state_nx = RUN;
            speed_nx = ramp_from_zero;
          end
        end
        RUN: begin
          if (pb) begin
            if (direction != dir_out) begin
              // Start the reversal on this boundary: first decel step now.
              speed_nx = ramp_down;
              if (ramp_down == '0) begin
                state_nx = DEAD;
                dead_nx  = DEAD_LOAD;
              end else begin
                state_nx = DECEL;
              end
            end else begin
              speed_nx = ramp_run;
              if (ramp_run == '0 && speed == '0) state_nx = IDLE;
            end
          end
        end
        DECEL: begin
          if (pb) begin
            speed_nx = ramp_down;
            if (ramp_down == '0) begin
              state_nx = DEAD;
              dead_nx  = DEAD_LOAD;
            end
          end
        end
        DEAD: begin
          if (pb) begin
            if (dead_cnt <= DW'(1)) begin
              // Dead time over: latch the new direction and start ramping.
              dead_nx = '0;
              dir_nx  = direction;
              if (speed != '0) begin
                state_nx = RUN;
                speed_nx = ramp_from_zero;
              end else begin
                state_nx = IDLE;
              end
            end else begin
              dead_nx = dead_cnt - DW'(1);
            end
          end
        end
        BRAKE: begin
          state_nx = IDLE;
          speed_nx = '0;
        end
        default: begin
          state_nx = IDLE;
          speed_nx = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state       <= IDLE;
      presc       <= '0;
      pwm_cnt     <= '0;
      dead_cnt    <= '0;
      speed_out   <= '0;
      dir_out     <= 1'b0;
      motor_plus  <= 1'b0;
      motor_minus <= 1'b0;
      at_speed    <= 1'b1;
      reversing   <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      state     <= state_nx;
      speed_out <= speed_nx;
      dir_out   <= dir_nx;
      dead_cnt  <= dead_nx;
      // Brake engages on the same edge that samples brake_in; otherwise
      // the legs follow the current compare, so they lag it by one clock.
      if (brake_in) begin
        motor_plus  <= 1'b1;
        motor_minus <= 1'b1;
      end else if (state == RUN || state == DECEL) begin
        motor_plus  <= pwm_on & dir_out;
        motor_minus <= pwm_on & ~dir_out;
      end else begin
        motor_plus  <= 1'b0;
        motor_minus <= 1'b0;
      end
      // Status reflects the state/duty being entered on this edge.
      at_speed  <= (state_nx == IDLE || state_nx == RUN) && (speed_nx == speed);
      reversing <= (state_nx == DECEL || state_nx == DEAD);
    end
  end

endmodule

// File: tb/tb_motor_ramp_pwm.sv
// Bench for motor_ramp_pwm: directed scenarios plus random commands, every
// cycle compared against a period-level behavioural model of the driver.
module tb_motor_ramp_pwm;
  localparam int CD  = 2;
  localparam int W   = 4;
  localparam int RS  = 3;
  localparam int DP  = 2;
  localparam int PER = CD * (1 << W);
  localparam int TOP = (1 << W) - 1;

  localparam int M_IDLE = 0, M_RUN = 1, M_DECEL = 2, M_DEAD = 3, M_BRAKE = 4;

  logic         clk = 1'b0;
  logic         reset_in;
  logic [W-1:0] speed;
  logic         direction;
  logic         brake_in;
  logic         motor_plus, motor_minus;
  logic [W-1:0] speed_out;
  logic         dir_out, at_speed, reversing;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  motor_ramp_pwm #(.CLK_DIV(CD), .WIDTH(W), .RAMP_STEP(RS), .DEAD_PERIODS(DP)) dut (
    .clk_in(clk), .reset_in(reset_in), .speed(speed), .direction(direction),
    .brake_in(brake_in), .motor_plus(motor_plus), .motor_minus(motor_minus),
    .speed_out(speed_out), .dir_out(dir_out), .at_speed(at_speed), .reversing(reversing)
  );

  // Behavioural model: time is a clock count since reset release; the PWM
  // counter and period boundaries follow arithmetically from it.
  int m_mode, m_so, m_dir, m_dead, m_plus, m_minus, m_at, m_rev, m_cyc;

  function automatic int toward(input int cur, input int goal);
    int d;
    d = goal - cur;
    if (d >= -RS && d <= RS) return goal;
    return (d > 0) ? cur + RS : cur - RS;
  endfunction

  always @(posedge clk) begin
    int  pc;
    bit  pb;
    bit  on;
    if (!reset_in) begin
      m_mode = M_IDLE; m_so = 0; m_dir = 0; m_dead = 0;
      m_plus = 0; m_minus = 0; m_at = 1; m_rev = 0; m_cyc = 0;
    end else begin
      pc = (m_cyc / CD) % (TOP + 1);
      pb = ((m_cyc % PER) == PER - 1);
      on = (m_so > pc);
      if (brake_in) begin
        m_plus = 1; m_minus = 1;
      end else if (m_mode == M_RUN || m_mode == M_DECEL) begin
        m_plus = (on && m_dir == 1) ? 1 : 0;
        m_minus = (on && m_dir == 0) ? 1 : 0;
      end else begin
        m_plus = 0; m_minus = 0;
      end
      if (brake_in) begin
        m_mode = M_BRAKE; m_so = 0;
      end else if (m_mode == M_BRAKE) begin
        m_mode = M_IDLE;
      end else if (m_mode == M_IDLE) begin
        m_dir = int'(direction);
        if (pb && speed != 0) begin m_mode = M_RUN; m_so = toward(0, int'(speed)); end
      end else if (pb) begin
        if (m_mode == M_RUN && int'(direction) != m_dir) m_mode = M_DECEL;
        if (m_mode == M_RUN) begin
          m_so = toward(m_so, int'(speed));
          if (m_so == 0 && speed == 0) m_mode = M_IDLE;
        end else if (m_mode == M_DECEL) begin
          m_so = toward(m_so, 0);
          if (m_so == 0) begin m_mode = M_DEAD; m_dead = DP; end
        end else begin
          m_dead = m_dead - 1;
          if (m_dead == 0) begin
            m_dir = int'(direction);
            if (speed != 0) begin m_mode = M_RUN; m_so = toward(0, int'(speed)); end
            else m_mode = M_IDLE;
          end
        end
      end
      m_at  = ((m_mode == M_IDLE || m_mode == M_RUN) && m_so == int'(speed)) ? 1 : 0;
      m_rev = (m_mode == M_DECEL || m_mode == M_DEAD) ? 1 : 0;
      m_cyc = m_cyc + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_cycle();
    chk("plus",      motor_plus,  m_plus);
    chk("minus",     motor_minus, m_minus);
    chk("speed_out", speed_out,   m_so);
    chk("dir_out",   dir_out,     m_dir);
    chk("at_speed",  at_speed,    m_at);
    chk("reversing", reversing,   m_rev);
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int hi_p;
    int hi_m;
    int both;

    // Reset held with active commands and brake.
    reset_in = 1'b0; speed = 4'd10; direction = 1'b1; brake_in = 1'b1;
    run(5);
    chk("rst_plus", motor_plus, 0);
    chk("rst_minus", motor_minus, 0);
    chk("rst_speed", speed_out, 0);
    chk("rst_dir", dir_out, 0);
    chk("rst_at", at_speed, 1);
    chk("rst_rev", reversing, 0);
    reset_in = 1'b1;
    run(1);
    chk("brk_after_rst_plus", motor_plus, 1);
    chk("brk_after_rst_minus", motor_minus, 1);

    // Steady duty 4/16 forward.
    brake_in = 1'b0; speed = 4'd4; direction = 1'b1;
    run(PER * 4);
    chk("duty_speed", speed_out, 4);
    chk("duty_at", at_speed, 1);
    hi_p = 0; hi_m = 0;
    for (int i = 0; i < PER; i++) begin
      step();
      hi_p += int'(motor_plus);
      hi_m += int'(motor_minus);
    end
    chk("duty_plus_clocks", hi_p, 8);
    chk("duty_minus_clocks", hi_m, 0);

    // Ramp down to stop, then up in steps of RS, clamped at the target.
    speed = 4'd0;
    run(PER * 4);
    chk("stop_speed", speed_out, 0);
    speed = 4'd5;
    run(PER * 3);
    chk("ramp5", speed_out, 5);
    speed = 4'd15;
    run(PER * 5);
    chk("ramp15", speed_out, 15);

    // Reversal from full scale.
    direction = 1'b0;
    run(PER + 1);
    chk("rev_flag", reversing, 1);
    both = 0;
    for (int i = 0; i < PER * 14; i++) begin
      step();
      both += int'(motor_plus & motor_minus);
    end
    chk("rev_never_both", both, 0);
    chk("rev_dir", dir_out, 0);
    chk("rev_speed", speed_out, 15);

    // Brake mid-run, release, re-ramp from idle.
    brake_in = 1'b1;
    run(1);
    chk("brk_plus", motor_plus, 1);
    chk("brk_minus", motor_minus, 1);
    chk("brk_speed", speed_out, 0);
    brake_in = 1'b0;
    run(2);
    chk("brk_rel_plus", motor_plus, 0);
    chk("brk_rel_minus", motor_minus, 0);
    run(PER * 6);
    chk("brk_reramp", speed_out, 15);

    // Reset in the middle of a reversal.
    direction = 1'b1;
    run(PER * 3);
    chk("mid_decel_rev", reversing, 1);
    reset_in = 1'b0;
    run(1);
    chk("mid_rst_speed", speed_out, 0);
    chk("mid_rst_rev", reversing, 0);
    chk("mid_rst_at", at_speed, 1);
    chk("mid_rst_dir", dir_out, 0);
    reset_in = 1'b1;
    run(PER * 2);

    // Random command sequence against the model.
    for (int s = 0; s < 30; s++) begin
      speed     = W'($urandom_range(0, TOP));
      direction = 1'($urandom_range(0, 1));
      brake_in  = ($urandom_range(0, 9) == 0);
      reset_in  = ($urandom_range(0, 19) != 0);
      run($urandom_range(1, 96));
    end
    reset_in = 1'b1; brake_in = 1'b0;
    run(PER * 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/motor_ramp_pwm.md
# motor_ramp_pwm

Parametrised successor to the single-channel H-bridge PWM driver: converts a commanded speed and direction into `motor_plus`/`motor_minus` drive for one motor. It adds a configurable duty resolution, slew-limited speed ramping, a safe reversal sequence (decelerate, dead time, re-accelerate), an active brake and status outputs. It sits between the RC command decoder and the H-bridge pins.

## Interface
- `CLK_DIV`, 50: clk_in cycles per PWM tick (≥1).
- `WIDTH`, 8: speed/duty resolution in bits; PWM period = 2^WIDTH ticks.
- `RAMP_STEP`, 1: maximum change of the applied speed per PWM period (1..2^WIDTH-1).
- `DEAD_PERIODS`, 2: full PWM periods with both outputs low during reversal (≥1).

- `clk_in` in 1: sole clock, rising edge.
- `reset_in` in 1: synchronous, active-low reset.
- `speed` in WIDTH: target duty, 0 = stop.
- `direction` in 1: 1 = forward (drive on `motor_plus`), 0 = reverse (drive on `motor_minus`).
- `brake_in` in 1: active brake request, level-sensitive.
- `motor_plus` out 1: H-bridge plus leg, registered.
- `motor_minus` out 1: H-bridge minus leg, registered.
- `speed_out` out WIDTH: currently applied duty.
- `dir_out` out 1: currently applied direction.
- `at_speed` out 1: high when state is IDLE or RUN and `speed_out == speed`.
- `reversing` out 1: high in DECEL or DEAD.

## Operation
- Prescaler: counts 0..CLK_DIV-1; `tick` is asserted in the cycle it equals CLK_DIV-1, then it wraps to 0.
- PWM counter `pwm_cnt` (WIDTH bits): increments on `tick` and wraps 2^WIDTH-1 → 0. The `tick` causing that wrap is the period boundary `pb`.
- Duty compare: `on = (speed_out > pwm_cnt)`, giving duty speed_out/2^WIDTH. Full scale is (2^WIDTH-1)/2^WIDTH; 0 means never on.
- `speed_out`, `dir_out` and the FSM change only on `pb`, except for brake and reset. The new `speed_out` applies from `pwm_cnt = 0`.
- Ramp at `pb` toward goal G: if |G − speed_out| ≤ RAMP_STEP then speed_out = G, else speed_out ± RAMP_STEP. Compute in WIDTH+1 bits so there is no overflow or underflow wrap.
- FSM states, reset to IDLE:
  - IDLE: outputs low, speed_out = 0. `dir_out` follows `direction` every cycle. Go to RUN when speed ≠ 0.
  - RUN: G = speed. At `pb`, if direction ≠ dir_out, go to DECEL. If speed_out becomes 0 with speed = 0, go to IDLE.
  - DECEL: G = 0, ignoring `speed`. When speed_out reaches 0, go to DEAD and load the dead counter with DEAD_PERIODS.
  - DEAD: both outputs low. The counter decrements at `pb`. On expiry, dir_out takes `direction`, then go to RUN (or IDLE if speed = 0). If `direction` returns to its old value during DECEL or DEAD, the sequence still completes.
  - BRAKE: entered from any state on the first cycle `brake_in` = 1. `motor_plus` = `motor_minus` = 1 and speed_out = 0. When `brake_in` falls, go to IDLE on the next cycle. Brake has priority over everything except reset.
- Output mapping outside BRAKE/DEAD/IDLE: `motor_plus` = on & dir_out, `motor_minus` = on & ~dir_out.
- `motor_plus` and `motor_minus` are never both 1 outside BRAKE.

## Timing
- All outputs are registered. Reset values: `motor_plus` 0, `motor_minus` 0, `speed_out` 0, `dir_out` 0, `at_speed` 1, `reversing` 0. Prescaler, `pwm_cnt` and the dead counter are all 0.
- Reset applied mid-ramp, mid-reversal or mid-brake takes effect on the next edge and returns everything to the values above.
- PWM outputs lag the `pwm_cnt` compare by 1 clock. One PWM period = CLK_DIV·2^WIDTH clocks.
- A change on `speed` or `direction` is sampled at the next `pb`, so worst-case latency is one PWM period + 1 clock.
- A ramp from 0 to S takes ceil(S/RAMP_STEP) periods.
- Reversal from S takes ceil(S/RAMP_STEP) + DEAD_PERIODS periods, then re-ramps.
- Brake: both outputs go high 1 clock after `brake_in` is sampled high.

## Test plan
1. Reset: CLK_DIV=2, WIDTH=4. Hold reset_in=0 for 5 cycles with speed=10, direction=1, brake_in=1 → all outputs at reset values; after release, brake engages 1 cycle later.
2. Duty: RAMP_STEP=15, speed=4, direction=1 → from the first `pb`, speed_out=4; `motor_plus` high 8 of every 32 clocks; `motor_minus` stays 0; at_speed=1.
3. Ramp: RAMP_STEP=1, speed 0→5 → speed_out reads 1,2,3,4,5 at successive `pb`; at_speed rises with the 5th. Then speed→15 with RAMP_STEP=4 → 9, 13, 15.
4. Reversal: at speed_out=5, direction=1, RAMP_STEP=1, DEAD_PERIODS=2, set direction=0 → reversing=1; speed_out 4..0 over 5 periods; both outputs low for 2 more periods; dir_out=0; `motor_minus` ramps 1..5; the two outputs never both high.
5. Brake: assert brake_in mid-RUN → both outputs 1 next cycle, speed_out=0. Deassert → IDLE, then ramp from 1.
6. Reset mid-DECEL (speed_out=3) → next cycle all outputs at reset values, FSM in IDLE, reversal abandoned.
